// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY)
//   N_REQ/SEL_W : requester count and select width
//   onehot()    : select index -> one-hot grant vector
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational rotating-priority picker for 8 requesters.
//   req  : request vector
//   last : most recently served requester; last+1 has top priority
//   win  : index of first requester found scanning last+1, last+2, ... mod 8
//   any  : at least one request present (win is meaningless when 0)
module rr_pick_8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    // Scan from lowest to highest priority so the highest-priority hit
    // is the last assignment. Offset 8 wraps to last itself (lowest priority).
    always_comb begin
        win = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[last + SEL_W'(i)]) begin
                win = last + SEL_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter in front of a shared 8:1 operand mux.
//   clk, rst : clock and synchronous active-high reset
//   req      : per-requester request lines
//   a0..a7   : per-requester operands (DW bits)
//   grant    : one-hot grant, zero when idle
//   sel      : index of granted requester, held for the whole tenure
//   busy     : a grant is active
//   y        : registered a[sel], lags grant by one cycle
//   y_valid  : y holds data from an active grant
//
// state | meaning
// IDLE  | no grant; waiting for any request
// BUSY  | requester sel owns the mux for up to MAX_HOLD cycles
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int DW       = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [DW-1:0]    a0,
    input  logic [DW-1:0]    a1,
    input  logic [DW-1:0]    a2,
    input  logic [DW-1:0]    a3,
    input  logic [DW-1:0]    a4,
    input  logic [DW-1:0]    a5,
    input  logic [DW-1:0]    a6,
    input  logic [DW-1:0]    a7,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [DW-1:0]    y,
    output logic             y_valid
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [SEL_W-1:0]  last, last_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [DW-1:0]     y_nxt;
    logic              y_valid_nxt;

    logic [DW-1:0]     a_arr [N_REQ];
    logic [SEL_W-1:0]  pick_last;
    logic [SEL_W-1:0]  win;
    logic              any;
    logic              tenure_end;

    assign a_arr[0] = a0;
    assign a_arr[1] = a1;
    assign a_arr[2] = a2;
    assign a_arr[3] = a3;
    assign a_arr[4] = a4;
    assign a_arr[5] = a5;
    assign a_arr[6] = a6;
    assign a_arr[7] = a7;

    // While busy, the current holder becomes "last" at tenure end, so rotate
    // from sel directly; that lets the next winner be granted with no idle gap.
    assign pick_last  = (state == BUSY) ? sel : last;
    assign tenure_end = !req[sel] || (hold_cnt == HOLD_LAST);

    rr_pick_8 u_pick (
        .req  (req),
        .last (pick_last),
        .win  (win),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            last     <= SEL_W'(N_REQ - 1);
            hold_cnt <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            y        <= y_nxt;
            y_valid  <= y_valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        sel_nxt     = sel;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        y_nxt       = '0;
        y_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = BUSY;
                    grant_nxt = onehot(win);
                    sel_nxt   = win;
                    hold_nxt  = '0;
                end else begin
                    grant_nxt = '0;
                    sel_nxt   = '0;
                end
            end
            BUSY: begin
                y_nxt       = a_arr[sel];
                y_valid_nxt = 1'b1;
                if (!tenure_end) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end else begin
                    last_nxt = sel;
                    hold_nxt = '0;
                    if (any) begin
                        grant_nxt = onehot(win);
                        sel_nxt   = win;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        sel_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                sel_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int NCYC_RAND = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] a [8];
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [2:0] y;
    logic       y_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DW(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a0      (a[0]),
        .a1      (a[1]),
        .a2      (a[2]),
        .a3      (a[3]),
        .a4      (a[4]),
        .a5      (a[5]),
        .a6      (a[6]),
        .a7      (a[7]),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .y       (y),
        .y_valid (y_valid)
    );

    // Reference model: who owns the mux, how many cycles they have been served,
    // and who was served last. Winner found by plain modular scan.
    int m_busy, m_sel, m_last, m_served, m_y, m_yv;

    function automatic int pick(input int last_i, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last_i + k) % 8]) return (last_i + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [7:0] r_req);
        int ny, nyv, w;
        if (r_rst) begin
            m_busy = 0; m_sel = 0; m_last = 7; m_served = 0; m_y = 0; m_yv = 0;
            return;
        end
        ny  = m_busy ? int'(a[m_sel]) : 0;
        nyv = m_busy;
        if (m_busy == 0) begin
            w = pick(m_last, r_req);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_served = 0;
            end
        end else begin
            m_served++;
            if (!r_req[m_sel] || m_served == MAX_HOLD) begin
                m_last = m_sel;
                w = pick(m_last, r_req);
                if (w >= 0) begin
                    m_sel = w; m_served = 0;
                end else begin
                    m_busy = 0; m_sel = 0; m_served = 0;
                end
            end
        end
        m_y  = ny;
        m_yv = nyv;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".grant"},   int'(grant),   m_busy ? (1 << m_sel) : 0);
        chk({tag, ".sel"},     int'(sel),     m_sel);
        chk({tag, ".busy"},    int'(busy),    m_busy);
        chk({tag, ".y"},       int'(y),       m_y);
        chk({tag, ".y_valid"}, int'(y_valid), m_yv);
        chk({tag, ".onehot"},  int'($onehot0(grant)), 1);
    endtask

    // Apply inputs, take one edge, update model, sample #1 after the edge.
    task automatic tick(input logic t_rst, input logic [7:0] t_req);
        rst = t_rst;
        req = t_req;
        @(posedge clk);
        model_step(t_rst, t_req);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic [2:0] y;
        logic       yv;
    } vec_t;

    vec_t vt [$];

    initial begin
        int   k;
        logic hold_ok;
        rst = 1'b1;
        req = 8'h00;
        for (int i = 0; i < 8; i++) a[i] = 3'(i);
        m_busy = 0; m_sel = 0; m_last = 7; m_served = 0; m_y = 0; m_yv = 0;

        // rst req grant sel busy y yv  (values after the edge)
        vt.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 3'd2, 1'b1});
        vt.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd2, 1'b1});
        vt.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h42, 8'h40, 3'd6, 1'b1, 3'd3, 1'b1});
        vt.push_back('{1'b0, 8'h42, 8'h40, 3'd6, 1'b1, 3'd6, 1'b1});
        vt.push_back('{1'b0, 8'h42, 8'h40, 3'd6, 1'b1, 3'd6, 1'b1});
        vt.push_back('{1'b0, 8'h42, 8'h40, 3'd6, 1'b1, 3'd6, 1'b1});
        vt.push_back('{1'b0, 8'h42, 8'h02, 3'd1, 1'b1, 3'd6, 1'b1});
        vt.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd1, 1'b1});
        vt.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].rst, vt[i].req);
            chk($sformatf("vec%0d.grant", i),   int'(grant),   int'(vt[i].grant));
            chk($sformatf("vec%0d.sel", i),     int'(sel),     int'(vt[i].sel));
            chk($sformatf("vec%0d.busy", i),    int'(busy),    int'(vt[i].busy));
            chk($sformatf("vec%0d.y", i),       int'(y),       int'(vt[i].y));
            chk($sformatf("vec%0d.y_valid", i), int'(y_valid), int'(vt[i].yv));
        end

        // All requesting: each requester holds exactly MAX_HOLD cycles, wraps 7->0.
        tick(1'b1, 8'hFF);
        check_model("rr_reset");
        for (k = 1; k <= 40; k++) begin
            tick(1'b0, 8'hFF);
            check_model("rr_all");
            chk("rr_all.sel_seq", int'(sel), ((k - 1) / MAX_HOLD) % 8);
            chk("rr_all.no_gap", int'(busy), 1);
        end

        // Lone requester re-granted back-to-back after each quantum.
        tick(1'b1, 8'h00);
        hold_ok = 1'b1;
        for (k = 1; k <= 10; k++) begin
            tick(1'b0, 8'h01);
            check_model("solo");
            if (grant != 8'h01 || !busy) hold_ok = 1'b0;
        end
        chk("solo.continuous", int'(hold_ok), 1);

        // Reset mid-tenure on requester 5, then restart from requester 0.
        tick(1'b1, 8'h00);
        for (k = 1; k <= 22; k++) tick(1'b0, 8'hFF);
        chk("midrst.pre_sel", int'(sel), 5);
        tick(1'b1, 8'hFF);
        check_model("midrst.reset");
        chk("midrst.grant0", int'(grant), 0);
        tick(1'b0, 8'hFF);
        check_model("midrst.restart");
        chk("midrst.sel0", int'(sel), 0);

        // Random traffic against the model.
        tick(1'b1, 8'h00);
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int c = 0; c < NCYC_RAND; c++) begin
                if ($urandom_range(3, 0) == 0) r = 8'($urandom);
                if ($urandom_range(7, 0) == 0) r = 8'h00;
                if ($urandom_range(15, 0) == 0) a[$urandom_range(7, 0)] = 3'($urandom);
                tick(($urandom_range(99, 0) == 0), r);
                check_model("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
